// File: rtl/ball_pkg.sv
// ----------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball slot manager: default geometry/slot
// parameters, the manager FSM state encoding, the queued hit-request record
// and the child X-position helpers used when a ball splits.
// ----------------------------------------------------------------------------
package ball_pkg;

  localparam int NUM_SLOTS    = 8;
  localparam int SPLIT_OFFSET = 16;
  localparam int X_MAX        = 639;
  localparam int START_Y      = 64;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_ALLOC_L = 3'd2,
    S_ALLOC_R = 3'd3,
    S_START   = 3'd4
  } ball_state_e;

  // One rope-ball hit waiting to be processed.
  typedef struct packed {
    logic [2:0]  slot;
    logic [1:0]  btype;
    logic [10:0] x;
    logic [10:0] y;
  } hit_req_t;

  // Left child X: parent X minus the split offset, clamped at the left edge.
  function automatic logic [10:0] split_left(input logic [10:0] x, input int offset);
    int xi;
    xi = int'(x);
    if (xi < offset) return 11'd0;
    return 11'(xi - offset);
  endfunction

  // Right child X: parent X plus the split offset, clamped at the right edge.
  function automatic logic [10:0] split_right(input logic [10:0] x, input int offset,
                                              input int x_max);
    int s;
    s = int'(x) + offset;
    if (s > x_max) return 11'(x_max);
    return 11'(s);
  endfunction

endpackage

// File: rtl/ball_slot_manager_hit_req_fifo.sv
// ----------------------------------------------------------------------------
// hit_req_fifo
// Two-entry synchronous FIFO of hit requests.
//   clk, resetN   : clock, asynchronous active-low reset
//   flush         : synchronous clear; wins over push and pop on the same edge
//   push, wdata   : write one entry (ignored while full)
//   pop           : drop the head entry (ignored while empty)
//   rdata         : current head entry (valid while !empty)
//   full, empty   : occupancy flags
// ----------------------------------------------------------------------------
module hit_req_fifo
  import ball_pkg::*;
(
  input  logic     clk,
  input  logic     resetN,
  input  logic     flush,
  input  logic     push,
  input  hit_req_t wdata,
  input  logic     pop,
  output hit_req_t rdata,
  output logic     full,
  output logic     empty
);

  hit_req_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ball_slot_manager.sv
// ----------------------------------------------------------------------------
// ball_slot_manager
// Tracks which ball slots are occupied, queues rope-ball hits, and splits a
// hit ball into two smaller children placed in the lowest free slots.
//   clk, resetN           : clock, asynchronous active-low reset
//   playmodeEnable        : low clears slots, queue and FSM, masks all pulses
//   levelStart            : pulse; flush everything and spawn the level ball
//   startType, startX     : level ball type / X
//   hitValid, hitReady    : hit request handshake
//   hitSlot/Type/X/Y      : hit request payload
//   slotActive            : per-slot occupancy
//   spawnValid + spawn*   : one-cycle slot load; data holds between loads
//   spawnOverflow         : pulse when a child is dropped (no free slot)
//   levelCleared          : pulse when the last ball has gone
//   fsm_state             : current FSM state, for observation
//
// Handshake: a hit transfers on a clk edge where hitValid && hitReady.
// hitReady depends only on FIFO fullness, never on hitValid; a request
// presented while hitReady is low is simply not taken.
// ----------------------------------------------------------------------------
module ball_slot_manager #(
  parameter int NUM_SLOTS    = ball_pkg::NUM_SLOTS,
  parameter int SPLIT_OFFSET = ball_pkg::SPLIT_OFFSET,
  parameter int X_MAX        = ball_pkg::X_MAX,
  parameter int START_Y      = ball_pkg::START_Y
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  playmodeEnable,
  input  logic                  levelStart,
  input  logic [1:0]            startType,
  input  logic [10:0]           startX,
  input  logic                  hitValid,
  input  logic [2:0]            hitSlot,
  input  logic [1:0]            hitType,
  input  logic [10:0]           hitX,
  input  logic [10:0]           hitY,
  output logic                  hitReady,
  output logic [NUM_SLOTS-1:0]  slotActive,
  output logic                  spawnValid,
  output logic [2:0]            spawnSlot,
  output logic [1:0]            spawnType,
  output logic [10:0]           spawnX,
  output logic [10:0]           spawnY,
  output logic                  spawnDir,
  output logic                  spawnOverflow,
  output logic                  levelCleared,
  output ball_pkg::ball_state_e fsm_state
);

  import ball_pkg::*;

  ball_state_e          state;
  hit_req_t             fifo_wdata;
  hit_req_t             head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_flush;
  logic                 fifo_pop;
  logic [NUM_SLOTS-1:0] prev_active;
  logic [1:0]           cur_type;
  logic [10:0]          cur_x;
  logic [10:0]          cur_y;
  logic [1:0]           lvl_type;
  logic [10:0]          lvl_x;
  logic                 free_found;
  logic [2:0]           free_idx;

  assign fsm_state  = state;
  assign hitReady   = !fifo_full;
  assign fifo_wdata = '{slot: hitSlot, btype: hitType, x: hitX, y: hitY};
  // A level start or leaving play mode discards queued and same-edge hits.
  assign fifo_flush = !playmodeEnable || levelStart;
  assign fifo_pop   = (state == S_POP);

  hit_req_fifo u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .flush  (fifo_flush),
    .push   (hitValid),
    .wdata  (fifo_wdata),
    .pop    (fifo_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slotActive[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      slotActive    <= '0;
      prev_active   <= '0;
      spawnValid    <= 1'b0;
      spawnOverflow <= 1'b0;
      levelCleared  <= 1'b0;
      spawnSlot     <= 3'd0;
      spawnType     <= 2'd0;
      spawnX        <= 11'd0;
      spawnY        <= 11'd0;
      spawnDir      <= 1'b0;
      cur_type      <= 2'd0;
      cur_x         <= 11'd0;
      cur_y         <= 11'd0;
      lvl_type      <= 2'd0;
      lvl_x         <= 11'd0;
    end else begin
      spawnValid    <= 1'b0;
      spawnOverflow <= 1'b0;
      levelCleared  <= 1'b0;
      prev_active   <= slotActive;

      if (!playmodeEnable) begin
        state       <= S_IDLE;
        slotActive  <= '0;
        // Forget the old occupancy so re-entering play cannot fake a clear.
        prev_active <= '0;
      end else if (levelStart) begin
        state      <= S_START;
        slotActive <= '0;
        lvl_type   <= startType;
        lvl_x      <= startX;
      end else begin
        levelCleared <= (state == S_IDLE) && fifo_empty &&
                        (slotActive == '0) && (prev_active != '0);
        case (state)
          S_IDLE: begin
            if (!fifo_empty) state <= S_POP;
          end
          S_POP: begin
            cur_type                <= head.btype;
            cur_x                   <= head.x;
            cur_y                   <= head.y;
            slotActive[head.slot]   <= 1'b0;
            // Freed or type-0 balls produce no children.
            if (head.btype != 2'd0 && slotActive[head.slot]) state <= S_ALLOC_L;
            else                                              state <= S_IDLE;
          end
          S_ALLOC_L: begin
            if (free_found) begin
              spawnValid           <= 1'b1;
              spawnSlot            <= free_idx;
              spawnType            <= cur_type - 2'd1;
              spawnX               <= split_left(cur_x, SPLIT_OFFSET);
              spawnY               <= cur_y;
              spawnDir             <= 1'b0;
              slotActive[free_idx] <= 1'b1;
            end else begin
              spawnOverflow <= 1'b1;
            end
            state <= S_ALLOC_R;
          end
          S_ALLOC_R: begin
            if (free_found) begin
              spawnValid           <= 1'b1;
              spawnSlot            <= free_idx;
              spawnType            <= cur_type - 2'd1;
              spawnX               <= split_right(cur_x, SPLIT_OFFSET, X_MAX);
              spawnY               <= cur_y;
              spawnDir             <= 1'b1;
              slotActive[free_idx] <= 1'b1;
            end else begin
              spawnOverflow <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_START: begin
            spawnValid    <= 1'b1;
            spawnSlot     <= 3'd0;
            spawnType     <= lvl_type;
            spawnX        <= lvl_x;
            spawnY        <= 11'(START_Y);
            spawnDir      <= 1'b1;
            slotActive[0] <= 1'b1;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_slot_manager.sv
module tb_ball_slot_manager;
  import ball_pkg::*;

  localparam int W = 29;  // {overflow, slot, type, x, y, dir}

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        playmodeEnable = 1'b0;
  logic        levelStart = 1'b0;
  logic [1:0]  startType = 2'd0;
  logic [10:0] startX = 11'd0;
  logic        hitValid = 1'b0;
  logic [2:0]  hitSlot = 3'd0;
  logic [1:0]  hitType = 2'd0;
  logic [10:0] hitX = 11'd0;
  logic [10:0] hitY = 11'd0;
  logic        hitReady;
  logic [7:0]  slotActive;
  logic        spawnValid;
  logic [2:0]  spawnSlot;
  logic [1:0]  spawnType;
  logic [10:0] spawnX;
  logic [10:0] spawnY;
  logic        spawnDir;
  logic        spawnOverflow;
  logic        levelCleared;
  ball_state_e fsm_state;

  ball_slot_manager dut (
    .clk(clk), .resetN(resetN), .playmodeEnable(playmodeEnable), .levelStart(levelStart),
    .startType(startType), .startX(startX), .hitValid(hitValid), .hitSlot(hitSlot),
    .hitType(hitType), .hitX(hitX), .hitY(hitY), .hitReady(hitReady),
    .slotActive(slotActive), .spawnValid(spawnValid), .spawnSlot(spawnSlot),
    .spawnType(spawnType), .spawnX(spawnX), .spawnY(spawnY), .spawnDir(spawnDir),
    .spawnOverflow(spawnOverflow), .levelCleared(levelCleared), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int             checks = 0;
  int             fails = 0;
  int             cleared_cnt = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   act_q[$];
  logic [7:0]     m_active;
  logic [W-1:0]   got;
  localparam logic [W-1:0] OVF = {1'b1, 28'd0};

  function automatic logic [W-1:0] pack_spawn(input int slot, input int btype, input int x,
                                               input int y, input int dir);
    return {1'b0, 3'(slot), 2'(btype), 11'(x), 11'(y), 1'(dir)};
  endfunction

  // Monitor: record every slot load / dropped child, count clear pulses.
  always @(negedge clk) begin
    if (resetN) begin
      if (spawnValid) act_q.push_back({1'b0, spawnSlot, spawnType, spawnX, spawnY, spawnDir});
      if (spawnOverflow) act_q.push_back(OVF);
      if (levelCleared) cleared_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!m_active[i]) return i;
    return -1;
  endfunction

  task automatic model_level_start(input int btype, input int x);
    m_active = 8'h01;
    exp_q.push_back(pack_spawn(0, btype, x, START_Y, 1));
  endtask

  task automatic model_hit(input int slot, input int btype, input int x, input int y);
    int f;
    int cx;
    if (m_active[slot] && btype > 0) begin
      m_active[slot] = 1'b0;
      f = lowest_free();
      cx = (x < SPLIT_OFFSET) ? 0 : x - SPLIT_OFFSET;
      if (f < 0) exp_q.push_back(OVF);
      else begin
        m_active[f] = 1'b1;
        exp_q.push_back(pack_spawn(f, btype - 1, cx, y, 0));
      end
      f = lowest_free();
      cx = (x + SPLIT_OFFSET > X_MAX) ? X_MAX : x + SPLIT_OFFSET;
      if (f < 0) exp_q.push_back(OVF);
      else begin
        m_active[f] = 1'b1;
        exp_q.push_back(pack_spawn(f, btype - 1, cx, y, 1));
      end
    end else begin
      m_active[slot] = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_hit(input int slot, input int btype, input int x, input int y);
    hitValid = 1'b1;
    hitSlot  = 3'(slot);
    hitType  = 2'(btype);
    hitX     = 11'(x);
    hitY     = 11'(y);
    step(1);
    hitValid = 1'b0;
  endtask

  task automatic do_level_start(input int btype, input int x);
    levelStart = 1'b1;
    startType  = 2'(btype);
    startX     = 11'(x);
    step(1);
    levelStart = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetN = 1'b0;
    step(2);
    resetN = 1'b1;
    step(1);
    checks++;
    if (slotActive !== 8'h00) begin
      fails++; $display("FAIL reset_slots: got %0h expected 0", slotActive);
    end
    checks++;
    if ({spawnValid, spawnOverflow, levelCleared} !== 3'b000) begin
      fails++; $display("FAIL reset_pulses: got %b expected 000", {spawnValid, spawnOverflow, levelCleared});
    end
    checks++;
    if ({spawnSlot, spawnType, spawnX, spawnY, spawnDir} !== 28'd0) begin
      fails++; $display("FAIL reset_data: got %0h expected 0", {spawnSlot, spawnType, spawnX, spawnY, spawnDir});
    end
    checks++;
    if (hitReady !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b expected 1", hitReady);
    end
    checks++;
    if (fsm_state !== S_IDLE) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE);
    end
  endtask

  task automatic test_level_start;
    playmodeEnable = 1'b1;
    step(1);
    do_level_start(3, 300);
    checks++;
    if (fsm_state !== S_START || spawnValid !== 1'b0) begin
      fails++; $display("FAIL lvl_enter_start: got state %0d valid %b expected %0d 0", fsm_state, spawnValid, S_START);
    end
    step(1);
    got = {spawnValid, spawnSlot, spawnType, spawnX, spawnY, spawnDir};
    checks++;
    if (got !== {1'b1, 3'd0, 2'd3, 11'd300, 11'd64, 1'b1}) begin
      fails++; $display("FAIL lvl_spawn: got %0h expected %0h", got, {1'b1, 3'd0, 2'd3, 11'd300, 11'd64, 1'b1});
    end
    checks++;
    if (slotActive !== 8'h01) begin
      fails++; $display("FAIL lvl_slots: got %0h expected 01", slotActive);
    end
    step(1);
    checks++;
    if (spawnValid !== 1'b0 || spawnX !== 11'd300 || spawnType !== 2'd3) begin
      fails++; $display("FAIL lvl_hold: got valid %b x %0d type %0d expected 0 300 3", spawnValid, spawnX, spawnType);
    end
  endtask

  task automatic test_split;
    drive_hit(0, 3, 300, 200);   // accepted at edge E
    step(1);                     // E+1
    checks++;
    if (slotActive !== 8'h01) begin
      fails++; $display("FAIL split_e1_slots: got %0h expected 01", slotActive);
    end
    step(1);                     // E+2
    checks++;
    if (slotActive !== 8'h00 || spawnValid !== 1'b0) begin
      fails++; $display("FAIL split_e2_free: got slots %0h valid %b expected 00 0", slotActive, spawnValid);
    end
    step(1);                     // E+3
    got = {spawnValid, spawnSlot, spawnType, spawnX, spawnY, spawnDir};
    checks++;
    if (got !== {1'b1, 3'd0, 2'd2, 11'd284, 11'd200, 1'b0}) begin
      fails++; $display("FAIL split_left: got %0h expected %0h", got, {1'b1, 3'd0, 2'd2, 11'd284, 11'd200, 1'b0});
    end
    step(1);                     // E+4
    got = {spawnValid, spawnSlot, spawnType, spawnX, spawnY, spawnDir};
    checks++;
    if (got !== {1'b1, 3'd1, 2'd2, 11'd316, 11'd200, 1'b1}) begin
      fails++; $display("FAIL split_right: got %0h expected %0h", got, {1'b1, 3'd1, 2'd2, 11'd316, 11'd200, 1'b1});
    end
    checks++;
    if (slotActive !== 8'h03 || fsm_state !== S_IDLE) begin
      fails++; $display("FAIL split_done: got slots %0h state %0d expected 03 %0d", slotActive, fsm_state, S_IDLE);
    end
    step(1);
    checks++;
    if (spawnValid !== 1'b0 || spawnX !== 11'd316) begin
      fails++; $display("FAIL split_hold: got valid %b x %0d expected 0 316", spawnValid, spawnX);
    end
  endtask

  task automatic test_saturation;
    act_q.delete(); exp_q.delete();
    do_level_start(1, 5); model_level_start(1, 5); step(2);
    model_hit(0, 1, 5, 100); drive_hit(0, 1, 5, 100); step(6);
    do_level_start(1, 630); model_level_start(1, 630); step(2);
    model_hit(0, 1, 630, 100); drive_hit(0, 1, 630, 100); step(6);
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL sat_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL sat_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow;
    act_q.delete(); exp_q.delete();
    do_level_start(3, 320); model_level_start(3, 320); step(2);
    for (int k = 0; k < 8; k++) begin
      model_hit(0, 3, 320, 100);
      drive_hit(0, 3, 320, 100);
      step(5);
    end
    checks++;
    if (slotActive !== 8'hff) begin
      fails++; $display("FAIL ovf_slots: got %0h expected ff", slotActive);
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL ovf_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL ovf_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    act_q.delete(); exp_q.delete();
    do_level_start(3, 300); model_level_start(3, 300); step(2);
    hitValid = 1'b1; hitSlot = 3'd0; hitType = 2'd3; hitX = 11'd300; hitY = 11'd200;
    checks++;
    if (hitReady !== 1'b1) begin
      fails++; $display("FAIL b2b_ready1: got %b expected 1", hitReady);
    end
    model_hit(0, 3, 300, 200);
    step(1);
    hitSlot = 3'd1; hitType = 2'd2; hitX = 11'd316; hitY = 11'd200;
    checks++;
    if (hitReady !== 1'b1) begin
      fails++; $display("FAIL b2b_ready2: got %b expected 1", hitReady);
    end
    model_hit(1, 2, 316, 200);
    step(1);
    hitSlot = 3'd2; hitType = 2'd3; hitX = 11'd500; hitY = 11'd100;
    checks++;
    if (hitReady !== 1'b0) begin
      fails++; $display("FAIL b2b_ready3: got %b expected 0", hitReady);
    end
    step(1);
    hitValid = 1'b0;
    step(14);
    checks++;
    if (slotActive !== m_active) begin
      fails++; $display("FAIL b2b_slots: got %0h expected %0h", slotActive, m_active);
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL b2b_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL b2b_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_clear;
    int base;
    do_level_start(2, 300); step(2);
    drive_hit(0, 2, 300, 200); step(5);
    drive_hit(0, 1, 284, 200); step(5);
    checks++;
    if (slotActive !== 8'h07) begin
      fails++; $display("FAIL clr_setup: got %0h expected 07", slotActive);
    end
    drive_hit(0, 0, 0, 0); drive_hit(1, 0, 0, 0); step(8);
    checks++;
    if (slotActive !== 8'h04) begin
      fails++; $display("FAIL clr_only2: got %0h expected 04", slotActive);
    end
    base = cleared_cnt;
    act_q.delete();
    drive_hit(2, 0, 10, 10); step(8);
    checks++;
    if (slotActive !== 8'h00 || act_q.size() !== 0) begin
      fails++; $display("FAIL clr_free: got slots %0h spawns %0d expected 00 0", slotActive, act_q.size());
    end
    checks++;
    if (cleared_cnt - base !== 1) begin
      fails++; $display("FAIL clr_pulse: got %0d expected 1", cleared_cnt - base);
    end
    drive_hit(2, 3, 10, 10); step(8);
    checks++;
    if (act_q.size() !== 0 || slotActive !== 8'h00 || cleared_cnt - base !== 1) begin
      fails++; $display("FAIL clr_dup: got spawns %0d slots %0h pulses %0d expected 0 00 1",
                        act_q.size(), slotActive, cleared_cnt - base);
    end
  endtask

  task automatic test_abort;
    int base;
    // levelStart while a split is allocating, with a hit offered on that edge
    act_q.delete(); exp_q.delete();
    do_level_start(3, 300); model_level_start(3, 300); step(1);
    drive_hit(0, 3, 300, 200);          // edge E
    drive_hit(0, 2, 100, 100);          // edge E+1, stays queued
    step(1);                            // E+2
    checks++;
    if (fsm_state !== S_ALLOC_L) begin
      fails++; $display("FAIL abort_in_alloc: got %0d expected %0d", fsm_state, S_ALLOC_L);
    end
    levelStart = 1'b1; startType = 2'd2; startX = 11'd200;
    hitValid = 1'b1; hitSlot = 3'd0; hitType = 2'd3; hitX = 11'd50; hitY = 11'd50;
    step(1);                            // E+3
    levelStart = 1'b0; hitValid = 1'b0;
    model_level_start(2, 200);
    checks++;
    if (spawnValid !== 1'b0 || slotActive !== 8'h00 || fsm_state !== S_START) begin
      fails++; $display("FAIL abort_ls: got valid %b slots %0h state %0d expected 0 00 %0d",
                        spawnValid, slotActive, fsm_state, S_START);
    end
    step(12);
    checks++;
    if (slotActive !== 8'h01) begin
      fails++; $display("FAIL abort_ls_slots: got %0h expected 01", slotActive);
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL abort_ls_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL abort_ls_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end

    // play mode dropped between the left and right child
    act_q.delete(); exp_q.delete();
    do_level_start(3, 300); model_level_start(3, 300); step(1);
    base = cleared_cnt;
    drive_hit(0, 3, 300, 200);          // edge E
    step(2);                            // E+2
    step(1);                            // E+3: left child loads
    exp_q.push_back(pack_spawn(0, 2, 284, 200, 0));
    playmodeEnable = 1'b0;
    step(1);                            // E+4
    checks++;
    if (spawnValid !== 1'b0 || slotActive !== 8'h00 || fsm_state !== S_IDLE) begin
      fails++; $display("FAIL abort_pm: got valid %b slots %0h state %0d expected 0 00 %0d",
                        spawnValid, slotActive, fsm_state, S_IDLE);
    end
    levelStart = 1'b1; startType = 2'd3; startX = 11'd100;
    step(1);
    levelStart = 1'b0;
    step(1);
    checks++;
    if (slotActive !== 8'h00 || fsm_state !== S_IDLE) begin
      fails++; $display("FAIL abort_pm_ls_ignored: got slots %0h state %0d expected 00 %0d",
                        slotActive, fsm_state, S_IDLE);
    end
    playmodeEnable = 1'b1;
    step(10);
    checks++;
    if (cleared_cnt - base !== 0) begin
      fails++; $display("FAIL abort_pm_cleared: got %0d expected 0", cleared_cnt - base);
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL abort_pm_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL abort_pm_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    int n, slot, t, x, y, sx;
    act_q.delete(); exp_q.delete();
    sx = $urandom_range(0, X_MAX);
    do_level_start(3, sx); model_level_start(3, sx); step(2);
    for (int it = 0; it < 40; it++) begin
      if (m_active == 8'h00) begin
        sx = $urandom_range(0, X_MAX);
        do_level_start(3, sx); model_level_start(3, sx); step(2);
      end
      n = ($urandom_range(0, 3) == 0) ? 2 : 1;
      for (int k = 0; k < n; k++) begin
        if (m_active == 8'h00 || $urandom_range(0, 7) == 0) slot = $urandom_range(0, 7);
        else begin
          do slot = $urandom_range(0, 7); while (!m_active[slot]);
        end
        t = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3);
        x = $urandom_range(0, X_MAX);
        y = $urandom_range(0, 479);
        model_hit(slot, t, x, y);
        drive_hit(slot, t, x, y);
      end
      step((n == 2) ? 10 : 6);
      checks++;
      if (slotActive !== m_active) begin
        fails++; $display("FAIL rand_slots[%0d]: got %0h expected %0h", it, slotActive, m_active);
      end
    end
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL rand_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL rand_event[%0d]: got %0h expected %0h", i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_active = 8'h00;
    test_reset;
    test_level_start;
    test_split;
    test_saturation;
    test_overflow;
    test_back_to_back;
    test_clear;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
